// File: rtl/shift_sequencer_if.sv
// Decode-to-shifter request bus and the shifter's stall/result return path.
// The processor side is the master, the shift_sequencer is the slave.
interface shift_sequencer_if;
    logic        start;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        illegal;

    modport master (
        output start, funct, shamt, rs_val, rt_val,
        input  stall, busy, done, result, illegal
    );

    modport slave (
        input  start, funct, shamt, rs_val, rt_val,
        output stall, busy, done, result, illegal
    );
endinterface

// File: rtl/shift_sequencer.sv
// Iterative MIPS-32 shift unit: shifts at most MAX_STEP positions per cycle,
// stalls the pipeline while working and pulses done with the final result.
module shift_sequencer #(
    parameter int MAX_STEP = 8
) (
    input  logic              clk,
    input  logic              reset,
    shift_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    // Amounts never exceed 31, so a 32-wide step is the same as "all remaining".
    localparam logic [4:0] STEP_CAP = (MAX_STEP >= 32) ? 5'd31 : 5'(MAX_STEP);

    state_t      state_reg, state_next;
    logic [31:0] data_reg, data_next;
    logic [31:0] result_reg, result_next;
    logic [4:0]  remain_reg, remain_next;
    logic        left_reg, left_next;
    logic        arith_reg, arith_next;
    logic        sign_reg, sign_next;
    logic        illegal_reg, illegal_next;

    logic        is_shift;
    logic [4:0]  accept_amount;
    logic [4:0]  step;
    logic        fill;
    logic [31:0] shifted;
    logic        unused_ok;

    // Only rs_val[4:0] carries a shift amount; the rest of rs is don't-care.
    assign unused_ok = &{1'b0, bus.rs_val[31:5]};

    // Shift functs are 000xyz with yz != 01; bit 2 selects the variable form.
    assign is_shift      = (bus.funct[5:3] == 3'b000) && (bus.funct[1:0] != 2'b01);
    assign accept_amount = !is_shift     ? 5'd0 :
                           bus.funct[2]  ? bus.rs_val[4:0] : bus.shamt;

    assign step    = (remain_reg > STEP_CAP) ? STEP_CAP : remain_reg;
    assign fill    = arith_reg & sign_reg;
    assign shifted = left_reg ? (data_reg << step)
                              : ((data_reg >> step) | ({32{fill}} & ~(32'hFFFF_FFFF >> step)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            data_reg    <= 32'h0;
            result_reg  <= 32'h0;
            remain_reg  <= 5'd0;
            left_reg    <= 1'b0;
            arith_reg   <= 1'b0;
            sign_reg    <= 1'b0;
            illegal_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            data_reg    <= data_next;
            result_reg  <= result_next;
            remain_reg  <= remain_next;
            left_reg    <= left_next;
            arith_reg   <= arith_next;
            sign_reg    <= sign_next;
            illegal_reg <= illegal_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        data_next    = data_reg;
        result_next  = result_reg;
        remain_next  = remain_reg;
        left_next    = left_reg;
        arith_next   = arith_reg;
        sign_next    = sign_reg;
        illegal_next = illegal_reg;

        unique case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    data_next   = bus.rt_val;
                    remain_next = accept_amount;
                    left_next   = ~bus.funct[1];
                    arith_next  = bus.funct[1] & bus.funct[0];
                    sign_next   = bus.funct[1] & bus.funct[0] & bus.rt_val[31];
                    if (accept_amount == 5'd0) begin
                        state_next   = DONE;
                        result_next  = bus.rt_val;
                        illegal_next = ~is_shift;
                    end else begin
                        state_next   = SHIFT;
                    end
                end
            end
            SHIFT: begin
                data_next   = shifted;
                remain_next = remain_reg - step;
                // result is only updated on the edge that enters DONE
                if (remain_reg == step) begin
                    state_next   = DONE;
                    result_next  = shifted;
                    illegal_next = 1'b0;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.stall   = ((state_reg == IDLE) && bus.start) || (state_reg == SHIFT);
    assign bus.busy    = (state_reg == SHIFT) || (state_reg == DONE);
    assign bus.done    = (state_reg == DONE);
    assign bus.result  = result_reg;
    assign bus.illegal = illegal_reg;

endmodule
